// File: rtl/spine_uplink_scheduler.sv
// Steers packets from the leaf router's GPU/NI path onto the spine uplinks.
// Each packet goes to one spine, chosen by round-robin among the eligible spines; per-spine credits gate traffic.
module spine_uplink_scheduler #(
   parameter int DWIDTH     = 16,
   parameter int NSPINE     = 4,
   parameter int CREDIT_MAX = 4,
   parameter int CW         = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 arb_enable,
   input  logic [NSPINE-1:0]    spine_en,
   input  logic [DWIDTH-1:0]    in_data,
   input  logic                 in_valid,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic [DWIDTH-1:0]    out_data,
   output logic [NSPINE-1:0]    out_valid,
   output logic                 out_last,
   input  logic [NSPINE-1:0]    credit_return,
   output logic [NSPINE*CW-1:0] credit_cnt,
   output logic [1:0]           current_grant,
   output logic                 busy,
   output logic                 credit_err
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                         state_reg, state_next;
   logic [1:0]                     rr_ptr_reg;
   logic [1:0]                     grant_reg;
   logic [1:0]                     grant_sel;
   logic [1:0]                     sel;
   logic                           sel_found;
   logic                           accept;
   logic [NSPINE-1:0][CW-1:0]      credit_reg;
   logic [NSPINE-1:0][CW-1:0]      credit_next;
   logic [NSPINE-1:0]              eligible;
   logic [NSPINE-1:0]              credit_nz;
   logic [NSPINE-1:0]              send;
   logic [NSPINE-1:0]              full;
   logic [NSPINE-1:0]              err_hit;
   logic [DWIDTH-1:0]              out_data_reg;
   logic [NSPINE-1:0]              out_valid_reg;
   logic                           out_last_reg;
   logic                           credit_err_reg;

   // Per-spine credit bookkeeping. A send and a return in the same cycle cancel out.
   generate
      for (genvar gi = 0; gi < NSPINE; gi++) begin : g_spine
         assign credit_nz[gi] = (credit_reg[gi] != '0);
         assign eligible[gi]  = spine_en[gi] & credit_nz[gi];
         assign send[gi]      = accept & (grant_sel == 2'(gi));
         assign full[gi]      = (credit_reg[gi] == CW'(CREDIT_MAX));
         assign err_hit[gi]   = ~send[gi] & credit_return[gi] & full[gi];
         assign credit_next[gi] =
            (send[gi] & ~credit_return[gi])             ? credit_reg[gi] - CW'(1) :
            (~send[gi] & credit_return[gi] & ~full[gi]) ? credit_reg[gi] + CW'(1) :
                                                          credit_reg[gi];
         assign credit_cnt[gi*CW +: CW] = credit_reg[gi];
      end
   endgenerate

   // Round-robin search starting just after the last granted spine
   always_comb begin
      logic [1:0] idx;
      idx       = '0;
      sel       = '0;
      sel_found = 1'b0;
      for (int k = 1; k <= NSPINE; k++) begin
         idx = rr_ptr_reg + k[1:0];
         if (!sel_found && eligible[idx]) begin
            sel       = idx;
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      grant_sel  = grant_reg;
      case (state_reg)
         IDLE: begin
            in_ready  = arb_enable & sel_found;
            grant_sel = sel;
            if (in_valid && in_ready && !in_last) state_next = LOCKED;
         end
         LOCKED: begin
            in_ready = credit_nz[grant_reg];
            if (in_valid && in_ready && in_last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         rr_ptr_reg     <= 2'd3;
         grant_reg      <= '0;
         credit_reg     <= {NSPINE{CW'(CREDIT_MAX)}};
         out_data_reg   <= '0;
         out_valid_reg  <= '0;
         out_last_reg   <= 1'b0;
         credit_err_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         credit_reg <= credit_next;
         if (|err_hit) credit_err_reg <= 1'b1;
         if (accept) begin
            grant_reg     <= grant_sel;
            out_data_reg  <= in_data;
            out_last_reg  <= in_last;
            out_valid_reg <= NSPINE'(1) << grant_sel;
            if (state_reg == IDLE) rr_ptr_reg <= grant_sel;
         end else begin
            out_valid_reg <= '0;
         end
      end
   end

   assign out_data      = out_data_reg;
   assign out_valid     = out_valid_reg;
   assign out_last      = out_last_reg;
   assign current_grant = grant_reg;
   assign busy          = (state_reg == LOCKED);
   assign credit_err    = credit_err_reg;

endmodule
